// File: rtl/if_fetch_stage.sv
// if_fetch_stage -- instruction-fetch stage of a 5-stage MIPS pipeline.
//
// Holds the PC, drives a synchronous (1-cycle latency) instruction memory,
// tracks the single in-flight fetch and fills the IF/ID pipeline register.
// Handles stall (pc_write=0), flush (wrong-path kill), global enable and HALT.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable            0 freezes every register in the stage
//   next_pc           next PC from the PC-select mux
//   pc_write          0 = stall (hold PC, in-flight fetch and IF/ID)
//   flush             kill the in-flight wrong-path fetch, load next_pc
//   imem_addr         word address (pc[ADDR_WIDTH+1:2])
//   imem_rd_en        memory read enable; memory holds its output while low
//   imem_data         memory read data, valid one cycle after the address
//   pc, pc_plus4      current PC and pc+4 (combinational)
//   if_id_instr       IF/ID instruction
//   if_id_pc_plus4    IF/ID pc+4 of that instruction
//   if_id_valid       IF/ID holds a live instruction
//   halted            HALT fetched, stage frozen until reset
//   fetch_count       (only with FETCH_COUNT_EN) saturating count of valid
//                     instructions loaded into IF/ID
//
// Optional feature macro: FETCH_COUNT_EN
//
// state   | meaning
// --------+---------------------------------------------
// ST_RUN  | normal fetching
// ST_HALT | HALT reached IF/ID; absorbing until reset

module if_fetch_stage #(
    parameter int                   BUS_WIDTH   = 32,
    parameter int                   ADDR_WIDTH  = 10,
    parameter logic [BUS_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]           HALT_OPCODE = 6'b111111
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [BUS_WIDTH-1:0]  next_pc,
    input  logic                  pc_write,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_rd_en,
    input  logic [BUS_WIDTH-1:0]  imem_data,
    output logic [BUS_WIDTH-1:0]  pc,
    output logic [BUS_WIDTH-1:0]  pc_plus4,
    output logic [BUS_WIDTH-1:0]  if_id_instr,
    output logic [BUS_WIDTH-1:0]  if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic                 inflight_valid_q, inflight_valid_d;
    logic [BUS_WIDTH-1:0] inflight_pc4_q, inflight_pc4_d;
    logic [BUS_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic [BUS_WIDTH-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic                 halted_q, halted_d;

    logic run;
    logic advance;
    logic halt_hit;
    logic if_id_load_live;

    assign run        = (state_q == ST_RUN);
    assign advance    = enable & pc_write & run;
    assign imem_rd_en = enable & (pc_write | flush) & run;
    assign pc_plus4   = pc_q + BUS_WIDTH'(4);
    assign imem_addr  = pc_q[ADDR_WIDTH+1:2];

    // A HALT on the wrong path (arriving with flush) must be discarded.
    assign halt_hit = inflight_valid_q & ~flush & advance &
                      (imem_data[BUS_WIDTH-1 -: 6] == HALT_OPCODE);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc4_d   = inflight_pc4_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        halted_d         = halted_q;
        if_id_load_live  = 1'b0;

        if (!run) begin
            // HALT has already been handed to IF/ID; retire it after one cycle.
            if_id_valid_d = 1'b0;
        end else if (enable) begin
            if (flush) begin
                pc_d             = next_pc;
                inflight_pc4_d   = pc_plus4;
                inflight_valid_d = 1'b0;
                if_id_instr_d    = imem_data;
                if_id_pc_plus4_d = inflight_pc4_q;
                if_id_valid_d    = 1'b0;
            end else if (pc_write) begin
                if_id_instr_d    = imem_data;
                if_id_pc_plus4_d = inflight_pc4_q;
                if (halt_hit) begin
                    // PC stays at HALT address + 4; no further fetch issued.
                    if_id_valid_d    = 1'b1;
                    inflight_valid_d = 1'b0;
                    state_d          = ST_HALT;
                    halted_d         = 1'b1;
                    if_id_load_live  = 1'b1;
                end else begin
                    pc_d             = next_pc;
                    inflight_pc4_d   = pc_plus4;
                    inflight_valid_d = 1'b1;
                    if_id_valid_d    = inflight_valid_q;
                    if_id_load_live  = inflight_valid_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc4_q   <= '0;
            if_id_instr_q    <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_valid_q    <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc4_q   <= inflight_pc4_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            halted_q         <= halted_d;
        end
    end

    assign pc             = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign halted         = halted_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (if_id_load_live && fetch_count_q != 32'hFFFF_FFFF) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, stall, flush, enable
// freeze, HALT (incl. wrong-path HALT), reset mid-stall and PC wrap.

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pc_write;
    logic        flush;
    logic        use_tgt;
    logic [31:0] tgt;
    logic [31:0] next_pc;
    logic [9:0]  imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] pc, pc_plus4, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, halted;

    logic [31:0] next_pc_w;
    logic [9:0]  imem_addr_w;
    logic        imem_rd_en_w;
    logic [31:0] imem_data_w = 32'h0;
    logic [31:0] pc_w, pc_plus4_w, if_id_instr_w, if_id_pc_plus4_w;
    logic        if_id_valid_w, halted_w;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count, fetch_count_w;
`endif

    logic [31:0] mem [0:1023];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign next_pc   = use_tgt ? tgt : pc_plus4;
    assign next_pc_w = pc_plus4_w;

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= mem[imem_addr];
    end

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .enable(enable), .next_pc(next_pc),
        .pc_write(pc_write), .flush(flush),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
        .pc(pc), .pc_plus4(pc_plus4), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .halted(halted)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .next_pc(next_pc_w),
        .pc_write(1'b1), .flush(1'b0),
        .imem_addr(imem_addr_w), .imem_rd_en(imem_rd_en_w), .imem_data(imem_data_w),
        .pc(pc_w), .pc_plus4(pc_plus4_w), .if_id_instr(if_id_instr_w),
        .if_id_pc_plus4(if_id_pc_plus4_w), .if_id_valid(if_id_valid_w),
        .halted(halted_w)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count_w)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2001_0005;
        mem[1]  = 32'h2002_0007;
        mem[2]  = 32'hFC00_0000;
        mem[16] = 32'h2003_000A;

        reset = 1'b1; enable = 1'b1; pc_write = 1'b1; flush = 1'b0;
        use_tgt = 1'b0; tgt = 32'h0;
        #1;
        tick(); tick();

        // reset state
        chk("rst_pc",       pc,             32'h0);
        chk("rst_pc4",      pc_plus4,       32'h4);
        chk("rst_addr",     imem_addr,      10'h0);
        chk("rst_instr",    if_id_instr,    32'h0);
        chk("rst_ifpc4",    if_id_pc_plus4, 32'h0);
        chk("rst_valid",    if_id_valid,    1'b0);
        chk("rst_halted",   halted,         1'b0);
        chk("wrap_pc",      pc_w,           32'hFFFF_FFFC);
        chk("wrap_pc4",     pc_plus4_w,     32'h0);
        chk("wrap_addr",    imem_addr_w,    10'h3FF);

        // sequential fetch to HALT
        reset = 1'b0;
        tick();
        chk("seq_e1_pc",    pc,             32'h4);
        chk("seq_e1_valid", if_id_valid,    1'b0);
        chk("wrap_e1_pc",   pc_w,           32'h0);
        tick();
        chk("seq_e2_instr", if_id_instr,    32'h2001_0005);
        chk("seq_e2_pc4",   if_id_pc_plus4, 32'h4);
        chk("seq_e2_valid", if_id_valid,    1'b1);
        tick();
        chk("seq_e3_instr", if_id_instr,    32'h2002_0007);
        chk("seq_e3_pc4",   if_id_pc_plus4, 32'h8);
        chk("seq_e3_valid", if_id_valid,    1'b1);
        tick();
        chk("halt_instr",   if_id_instr,    32'hFC00_0000);
        chk("halt_valid",   if_id_valid,    1'b1);
        chk("halt_flag",    halted,         1'b1);
        chk("halt_pc",      pc,             32'hC);
        chk("halt_rden",    imem_rd_en,     1'b0);
`ifdef FETCH_COUNT_EN
        chk("halt_fcount",  fetch_count,    32'd3);
`endif
        tick();
        chk("halt_e5_valid", if_id_valid,   1'b0);
        chk("halt_e5_pc",    pc,            32'hC);
        flush = 1'b1; use_tgt = 1'b1; tgt = 32'h40; pc_write = 1'b0;
        tick();
        chk("halt_ign_pc",    pc,          32'hC);
        chk("halt_ign_flag",  halted,      1'b1);
        chk("halt_ign_valid", if_id_valid, 1'b0);
        flush = 1'b0; use_tgt = 1'b0; pc_write = 1'b1;

        reset = 1'b1;
        tick();
        chk("rst2_pc",     pc,     32'h0);
        chk("rst2_halted", halted, 1'b0);

        // stall after edge 2
        reset = 1'b0;
        tick(); tick();
        chk("st_pre_instr", if_id_instr, 32'h2001_0005);
        pc_write = 1'b0;
        #1;
        chk("st_rden", imem_rd_en, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_pc",    pc,             32'h8);
            chk("st_instr", if_id_instr,    32'h2001_0005);
            chk("st_ifpc4", if_id_pc_plus4, 32'h4);
        end
        pc_write = 1'b1;
        tick();
        chk("st_res_instr", if_id_instr,    32'h2002_0007);
        chk("st_res_pc4",   if_id_pc_plus4, 32'h8);
        chk("st_res_valid", if_id_valid,    1'b1);

        // reset asserted mid-stall
        pc_write = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_st_pc",     pc,             32'h0);
        chk("rst_st_instr",  if_id_instr,    32'h0);
        chk("rst_st_ifpc4",  if_id_pc_plus4, 32'h0);
        chk("rst_st_valid",  if_id_valid,    1'b0);
        chk("rst_st_halted", halted,         1'b0);
        reset = 1'b0; pc_write = 1'b1;

        // flush at pc=4 to 0x40, with pc_write low (flush wins)
        tick();
        chk("fl_pre_pc", pc, 32'h4);
        flush = 1'b1; use_tgt = 1'b1; tgt = 32'h40; pc_write = 1'b0;
        #1;
        chk("fl_rden", imem_rd_en, 1'b1);
        tick();
        chk("fl_pc",    pc,          32'h40);
        chk("fl_valid", if_id_valid, 1'b0);
        flush = 1'b0; use_tgt = 1'b0; pc_write = 1'b1;
        tick();
        chk("fl_e3_valid", if_id_valid, 1'b0);
        chk("fl_e3_pc",    pc,          32'h44);
        tick();
        chk("fl_e4_instr", if_id_instr,    32'h2003_000A);
        chk("fl_e4_pc4",   if_id_pc_plus4, 32'h44);
        chk("fl_e4_valid", if_id_valid,    1'b1);

        // enable low freezes everything, even with flush
        enable = 1'b0; flush = 1'b1; use_tgt = 1'b1; tgt = 32'h100;
        #1;
        chk("en_rden", imem_rd_en, 1'b0);
        tick();
        chk("en_pc",    pc,          32'h48);
        chk("en_instr", if_id_instr, 32'h2003_000A);
        chk("en_valid", if_id_valid, 1'b1);
        enable = 1'b1;

        // HALT arriving with flush is discarded
        tgt = 32'h8;
        tick();
        chk("hf_a_pc", pc, 32'h8);
        flush = 1'b0; use_tgt = 1'b0;
        tick();
        chk("hf_b_pc", pc, 32'hC);
        flush = 1'b1; use_tgt = 1'b1; tgt = 32'h0;
        tick();
        chk("hf_halted", halted,      1'b0);
        chk("hf_pc",     pc,          32'h0);
        chk("hf_valid",  if_id_valid, 1'b0);
        flush = 1'b0; use_tgt = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
